// File: rtl/espirometro_pkg.sv
// Shared definitions for the spirometer patient-parameter capture block:
// capture FSM states, global system-state encodings and default bounds.
package espirometro_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Global spirometer state machine encodings (ivStateMachine)
  localparam logic [1:0] SYS_CAPTURE = 2'd0;
  localparam logic [1:0] SYS_MEASURE = 2'd1;
  localparam logic [1:0] SYS_REPORT  = 2'd2;
  localparam logic [1:0] SYS_FAULT   = 2'd3;

  // Default legal range for a captured patient parameter
  localparam logic [7:0] DEF_MIN_VAL = 8'd10;
  localparam logic [7:0] DEF_MAX_VAL = 8'd250;

endpackage

// File: rtl/espirometro_chan_acc.sv
// Per-channel accumulator and shift-divide for the parameter capture block.
// Sums 2^LOG2_SAMPLES samples; on the final sample the truncated average of
// (accumulator + incoming sample) is loaded into the output register.
// Range comparators are only built when ESPIROMETRO_RANGE_CHECK_EN is defined.
module espirometro_chan_acc
  import espirometro_pkg::*;
#(
  parameter int             WIDTH        = 8,
  parameter int             LOG2_SAMPLES = 2,
  parameter logic [WIDTH-1:0] MIN_VAL    = DEF_MIN_VAL,
  parameter logic [WIDTH-1:0] MAX_VAL    = DEF_MAX_VAL
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             i_clear,
  input  logic             i_add,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_avg,
  output logic             o_range_err
);

  // Wide enough for 2^LOG2_SAMPLES full-scale samples, so it never wraps
  localparam int ACC_W = WIDTH + LOG2_SAMPLES;

  logic [ACC_W-1:0] r_acc;
  logic [WIDTH-1:0] r_avg;
  logic [ACC_W-1:0] w_sum;
  logic [WIDTH-1:0] w_avg_next;

  // The final sample is folded in combinationally so the average loads
  // on the very edge that accepts it.
  assign w_sum      = r_acc + ACC_W'(i_data);
  assign w_avg_next = w_sum[ACC_W-1:LOG2_SAMPLES];

  // Running sum: cleared on a new capture and after completion
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_acc <= '0;
    end else if (i_clear || i_load) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= w_sum;
    end
  end

  // Averaged output: changes only when a capture completes
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_avg <= '0;
    end else if (i_load) begin
      r_avg <= w_avg_next;
    end
  end

  assign o_avg = r_avg;

`ifdef ESPIROMETRO_RANGE_CHECK_EN
  // Flags the value about to be loaded as out of the legal range
  assign o_range_err = (w_avg_next < MIN_VAL) || (w_avg_next > MAX_VAL);
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/espirometro_param_capture.sv
// Multi-channel patient-parameter capture (weight, height, age, ...).
// A start request in the capture system state begins averaging of
// 2^LOG2_SAMPLES strobed samples per channel; leaving the capture state
// aborts. Optional range check enabled by ESPIROMETRO_RANGE_CHECK_EN.
module espirometro_param_capture
  import espirometro_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               NUM_CH        = 2,
  parameter int               LOG2_SAMPLES  = 2,
  parameter logic [1:0]       CAPTURE_STATE = SYS_CAPTURE,
  parameter logic [WIDTH-1:0] MIN_VAL       = DEF_MIN_VAL,
  parameter logic [WIDTH-1:0] MAX_VAL       = DEF_MAX_VAL
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iCE,
  input  logic                    iStart,
  input  logic [1:0]              ivStateMachine,
  input  logic [NUM_CH*WIDTH-1:0] ivData,
  output logic [NUM_CH*WIDTH-1:0] ovData,
  output logic                    oValid,
  output logic                    oBusy,
  output logic                    oError
);

  // One extra bit keeps the counter well-formed even when LOG2_SAMPLES is 0
  localparam int CNT_W = LOG2_SAMPLES + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((32'd1 << LOG2_SAMPLES) - 32'd1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_busy;
  logic             r_error;

  logic              w_match;
  logic              w_start;
  logic              w_take;
  logic              w_last;
  logic              w_add;
  logic              w_load;
  logic [NUM_CH-1:0] w_ch_err;

  assign w_match = (ivStateMachine == CAPTURE_STATE);
  // A start is honoured only outside ACCUM, so a capture cannot be restarted
  assign w_start = (r_state != ST_ACCUM) && iStart && w_match;
  assign w_take  = (r_state == ST_ACCUM) && w_match && iCE;
  assign w_last  = (r_count == LAST_CNT);
  assign w_add   = w_take && !w_last;
  assign w_load  = w_take && w_last;

  // Capture sequencing with registered valid/busy flags
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state <= ST_ACCUM;
            r_count <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (!w_match) begin
            // Left the capture state: discard the partial capture
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else if (w_load) begin
            r_state <= ST_DONE;
            r_count <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_add) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Error flag follows the valid flag: cleared on start, set at completion
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_error <= 1'b0;
    end else if (w_start) begin
      r_error <= 1'b0;
    end else if (w_load) begin
      r_error <= |w_ch_err;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      espirometro_chan_acc #(
        .WIDTH        (WIDTH),
        .LOG2_SAMPLES (LOG2_SAMPLES),
        .MIN_VAL      (MIN_VAL),
        .MAX_VAL      (MAX_VAL)
      ) u_chan_acc (
        .iClk        (iClk),
        .iReset      (iReset),
        .i_clear     (w_start),
        .i_add       (w_add),
        .i_load      (w_load),
        .i_data      (ivData[gi*WIDTH +: WIDTH]),
        .o_avg       (ovData[gi*WIDTH +: WIDTH]),
        .o_range_err (w_ch_err[gi])
      );
    end
  endgenerate

  assign oValid = r_valid;
  assign oBusy  = r_busy;
  assign oError = r_error;

endmodule

// File: tb/tb_espirometro_param_capture.sv
// Directed testbench for espirometro_param_capture (WIDTH=8, NUM_CH=2,
// LOG2_SAMPLES=2, CAPTURE_STATE=0). Expected oError depends on whether
// ESPIROMETRO_RANGE_CHECK_EN is defined for the build.
module tb_espirometro_param_capture;

  logic        iClk;
  logic        iReset;
  logic        iCE;
  logic        iStart;
  logic [1:0]  ivStateMachine;
  logic [15:0] ivData;
  logic [15:0] ovData;
  logic        oValid;
  logic        oBusy;
  logic        oError;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef ESPIROMETRO_RANGE_CHECK_EN
  localparam logic RANGE_ON = 1'b1;
`else
  localparam logic RANGE_ON = 1'b0;
`endif

  espirometro_param_capture #(
    .WIDTH         (8),
    .NUM_CH        (2),
    .LOG2_SAMPLES  (2),
    .CAPTURE_STATE (2'd0)
  ) dut (
    .iClk           (iClk),
    .iReset         (iReset),
    .iCE            (iCE),
    .iStart         (iStart),
    .ivStateMachine (ivStateMachine),
    .ivData         (ivData),
    .ovData         (ovData),
    .oValid         (oValid),
    .oBusy          (oBusy),
    .oError         (oError)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_capture();
    ivStateMachine = 2'd0;
    iStart = 1'b1;
    iCE    = 1'b0;
    step();
    iStart = 1'b0;
  endtask

  task automatic sample(input logic [7:0] ch0, input logic [7:0] ch1);
    ivData = {ch1, ch0};
    iCE    = 1'b1;
    step();
    iCE    = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1; iCE = 1'b0; iStart = 1'b0; ivStateMachine = 2'd0; ivData = '0;
    step(); step();
    iReset = 1'b0;
    step();
    total_cnt++;
    if ({ovData, oValid, oBusy, oError} !== 19'd0) $display("FAIL reset_outputs: got ovData=%h v=%b b=%b e=%b, want all 0", ovData, oValid, oBusy, oError);
    else pass_cnt++;
    $display("reset: ovData=%h oValid=%b oBusy=%b oError=%b", ovData, oValid, oBusy, oError);
  endtask

  task automatic test_basic();
    start_capture();
    total_cnt++;
    if (oBusy !== 1'b1 || oValid !== 1'b0) $display("FAIL basic_busy: got busy=%b valid=%b, want busy=1 valid=0", oBusy, oValid);
    else pass_cnt++;
    sample(8'd70, 8'd170);
    sample(8'd72, 8'd170);
    sample(8'd74, 8'd170);
    total_cnt++;
    if (oValid !== 1'b0) $display("FAIL basic_early_valid: got %b, want 0", oValid);
    else pass_cnt++;
    sample(8'd76, 8'd170);
    total_cnt++;
    if (ovData !== {8'd170, 8'd73} || oValid !== 1'b1 || oBusy !== 1'b0 || oError !== 1'b0)
      $display("FAIL basic_result: got ovData=%h v=%b b=%b e=%b, want ovData=aa49 v=1 b=0 e=0", ovData, oValid, oBusy, oError);
    else pass_cnt++;
    $display("basic: ovData=%h oValid=%b", ovData, oValid);
    // DONE holds its result across idle cycles
    step(); step();
    total_cnt++;
    if (ovData !== {8'd170, 8'd73} || oValid !== 1'b1) $display("FAIL basic_hold: got ovData=%h v=%b, want aa49 v=1", ovData, oValid);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [7:0] ch0_tab [4];
    int k;
    ch0_tab[0] = 8'd70; ch0_tab[1] = 8'd72; ch0_tab[2] = 8'd74; ch0_tab[3] = 8'd76;
    k = 0;
    start_capture();
    total_cnt++;
    if (oValid !== 1'b0 || ovData !== {8'd170, 8'd73}) $display("FAIL gaps_start: got v=%b ovData=%h, want v=0 ovData=aa49", oValid, ovData);
    else pass_cnt++;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      if (cyc == 1 || cyc == 4 || cyc == 5 || cyc == 9) begin
        ivData = {8'd170, ch0_tab[k]};
        iCE = 1'b1;
        k++;
      end else begin
        ivData = 16'hffff;
        iCE = 1'b0;
      end
      step();
      if (cyc == 8) begin
        total_cnt++;
        if (oValid !== 1'b0 || oBusy !== 1'b1) $display("FAIL gaps_mid: got v=%b b=%b, want v=0 b=1", oValid, oBusy);
        else pass_cnt++;
      end
    end
    iCE = 1'b0;
    total_cnt++;
    if (ovData !== {8'd170, 8'd73} || oValid !== 1'b1) $display("FAIL gaps_result: got ovData=%h v=%b, want aa49 v=1", ovData, oValid);
    else pass_cnt++;
    $display("gaps: ovData=%h oValid=%b", ovData, oValid);
  endtask

  task automatic test_abort();
    start_capture();
    sample(8'd10, 8'd30);
    sample(8'd20, 8'd40);
    ivStateMachine = 2'd1;
    step();
    total_cnt++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || ovData !== {8'd170, 8'd73})
      $display("FAIL abort_state: got b=%b v=%b ovData=%h, want b=0 v=0 ovData=aa49", oBusy, oValid, ovData);
    else pass_cnt++;
    // Start outside the capture state is ignored
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    total_cnt++;
    if (oBusy !== 1'b0) $display("FAIL abort_nomatch_start: got busy=%b, want 0", oBusy);
    else pass_cnt++;
    // Fresh capture: 100,100,100,104 -> 101 ; 20,21,22,23 -> 21
    start_capture();
    sample(8'd100, 8'd20);
    sample(8'd100, 8'd21);
    sample(8'd100, 8'd22);
    sample(8'd104, 8'd23);
    total_cnt++;
    if (ovData !== {8'd21, 8'd101} || oValid !== 1'b1) $display("FAIL abort_fresh: got ovData=%h v=%b, want 1565 v=1", ovData, oValid);
    else pass_cnt++;
    $display("abort: ovData=%h oValid=%b", ovData, oValid);
  endtask

  task automatic test_restart_ignored();
    start_capture();
    sample(8'd40, 8'd80);
    sample(8'd44, 8'd80);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    total_cnt++;
    if (oBusy !== 1'b1) $display("FAIL restart_busy: got %b, want 1", oBusy);
    else pass_cnt++;
    sample(8'd48, 8'd80);
    sample(8'd52, 8'd80);
    total_cnt++;
    if (ovData !== {8'd80, 8'd46} || oValid !== 1'b1) $display("FAIL restart_result: got ovData=%h v=%b, want 502e v=1", ovData, oValid);
    else pass_cnt++;
    $display("restart: ovData=%h oValid=%b", ovData, oValid);
  endtask

  task automatic test_range();
    start_capture();
    sample(8'd4, 8'd100);
    sample(8'd4, 8'd100);
    sample(8'd8, 8'd100);
    sample(8'd8, 8'd100);
    total_cnt++;
    if (ovData !== {8'd100, 8'd6} || oValid !== 1'b1 || oError !== RANGE_ON)
      $display("FAIL range_result: got ovData=%h v=%b e=%b, want 6406 v=1 e=%b", ovData, oValid, oError, RANGE_ON);
    else pass_cnt++;
    $display("range: ovData=%h oValid=%b oError=%b", ovData, oValid, oError);
    start_capture();
    total_cnt++;
    if (oError !== 1'b0 || oValid !== 1'b0) $display("FAIL range_clear: got e=%b v=%b, want e=0 v=0", oError, oValid);
    else pass_cnt++;
    ivStateMachine = 2'd2;
    step();
    ivStateMachine = 2'd0;
  endtask

  task automatic test_async_reset();
    start_capture();
    sample(8'd60, 8'd90);
    sample(8'd62, 8'd90);
    total_cnt++;
    if (oBusy !== 1'b1 || ovData !== {8'd100, 8'd6}) $display("FAIL areset_pre: got b=%b ovData=%h, want b=1 ovData=6406", oBusy, ovData);
    else pass_cnt++;
    #2;
    iReset = 1'b1;
    #1;
    total_cnt++;
    if ({ovData, oValid, oBusy, oError} !== 19'd0) $display("FAIL areset_immediate: got ovData=%h v=%b b=%b e=%b, want all 0", ovData, oValid, oBusy, oError);
    else pass_cnt++;
    $display("async_reset: ovData=%h oValid=%b oBusy=%b", ovData, oValid, oBusy);
    step();
    iReset = 1'b0;
    sample(8'd64, 8'd90);
    total_cnt++;
    if (oBusy !== 1'b0 || oValid !== 1'b0) $display("FAIL areset_idle: got b=%b v=%b, want b=0 v=0", oBusy, oValid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_restart_ignored();
    test_range();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
